// File: rtl/hamming_receptor.sv
// hamming_receptor: serial Hamming(7,4) receiver, or SECDED(8,4) when
// HAMMING_SECDED_EN is defined.
// It shifts in one coded bit per qualified cycle, position 1 first. When the
// last position arrives it decodes the frame, corrects any single-bit error,
// and strobes the result for one cycle.
//
// Ports:
//   clk        system clock (rising edge)
//   rst_n      asynchronous active-low reset
//   sin        serial coded bit
//   sin_valid  qualifies sin this cycle
//   sof        start of frame (with sin_valid): sin is codeword position 1
//   data       decoded nibble {pos7,pos6,pos5,pos3}
//   data_valid one-cycle strobe; data/syndrome/flags are valid while high
//   err_corr   a single-bit error was corrected (including parity positions)
//   syndrome   raw syndrome of the frame (0 = no error seen by the Hamming bits)
//   dbl_err    uncorrectable double error (SECDED only; otherwise always 0)
module hamming_receptor (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sin,
  input  logic       sin_valid,
  input  logic       sof,
  output logic [3:0] data,
  output logic       data_valid,
  output logic       err_corr,
  output logic [2:0] syndrome,
  output logic       dbl_err
);

`ifdef HAMMING_SECDED_EN
  localparam int N = 8;
`else
  localparam int N = 7;
`endif
  localparam logic [2:0] LAST = 3'(N-1);

  typedef enum logic {IDLE, SHIFT} state_t;

  typedef struct packed {
    logic [3:0] data;
    logic [2:0] syn;
    logic       err_corr;
    logic       dbl_err;
  } dec_t;

  state_t         state, nxt_state;
  logic [2:0]     cnt, nxt_cnt;   // positions captured so far in this frame
  logic [N-1:0]   cw;             // cw[i] holds codeword position i+1
  logic           cap, fin;
  logic [N-1:0]   word;           // complete frame, including the bit arriving now
  logic           flip;
  dec_t           dec;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
    end
  end

  // Next state. sof always restarts at position 1, so an aborted partial
  // frame simply gets overwritten and never reaches the decode step.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    cap       = 1'b0;
    fin       = 1'b0;
    case (state)
      IDLE: begin
        if (sin_valid && sof) begin
          cap       = 1'b1;
          nxt_state = SHIFT;
          nxt_cnt   = 3'd1;
        end
      end
      SHIFT: begin
        if (sin_valid) begin
          cap = 1'b1;
          if (sof) begin
            nxt_cnt = 3'd1;
          end else if (cnt == LAST) begin
            fin       = 1'b1;
            nxt_state = IDLE;
            nxt_cnt   = '0;
          end else begin
            nxt_cnt = cnt + 3'd1;
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  // Shift register, indexed by position so the decoder can read it directly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cw <= '0;
    end else if (cap) begin
      if (sof) cw <= {{(N-1){1'b0}}, sin};
      else     cw[cnt] <= sin;
    end
  end

  // Decode the frame as it completes. The last bit is still on sin, so it is
  // merged in here rather than waiting a cycle for it to land in cw.
  always_comb begin
    word       = cw;
    word[cnt]  = sin;
    dec        = '0;
    dec.syn[0] = word[0] ^ word[2] ^ word[4] ^ word[6];
    dec.syn[1] = word[1] ^ word[2] ^ word[5] ^ word[6];
    dec.syn[2] = word[3] ^ word[4] ^ word[5] ^ word[6];
`ifdef HAMMING_SECDED_EN
    // The overall parity check decides between a single error and a double
    // error: a nonzero syndrome with good overall parity means two bits flipped.
    dec.err_corr = ^word;
    dec.dbl_err  = (dec.syn != 3'd0) && !(^word);
`else
    dec.err_corr = (dec.syn != 3'd0);
    dec.dbl_err  = 1'b0;
`endif
    flip = (dec.syn != 3'd0) && !dec.dbl_err;
    // Only data positions need the correction applied. A flip on a parity
    // position (1, 2, 4) is reported through err_corr alone.
    dec.data[0] = word[2] ^ (flip && dec.syn == 3'd3);
    dec.data[1] = word[4] ^ (flip && dec.syn == 3'd5);
    dec.data[2] = word[5] ^ (flip && dec.syn == 3'd6);
    dec.data[3] = word[6] ^ (flip && dec.syn == 3'd7);
  end

  // Outputs are registered on the edge that captures the last position.
  // The results hold until the next frame completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data       <= '0;
      data_valid <= 1'b0;
      err_corr   <= 1'b0;
      syndrome   <= '0;
      dbl_err    <= 1'b0;
    end else begin
      data_valid <= fin;
      if (fin) begin
        data     <= dec.data;
        syndrome <= dec.syn;
        err_corr <= dec.err_corr;
        dbl_err  <= dec.dbl_err;
      end
    end
  end

endmodule

// File: tb/tb_hamming_receptor.sv
module tb_hamming_receptor;

`ifdef HAMMING_SECDED_EN
  localparam int N = 8;
`else
  localparam int N = 7;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sin = 1'b0, sin_valid = 1'b0, sof = 1'b0;
  logic [3:0] data;
  logic       data_valid, err_corr, dbl_err;
  logic [2:0] syndrome;

  hamming_receptor dut (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid), .sof(sof),
    .data(data), .data_valid(data_valid), .err_corr(err_corr),
    .syndrome(syndrome), .dbl_err(dbl_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] d;
    logic [2:0] s;
    logic       e;
    logic       db;
  } exp_t;

  exp_t sb[$];
  int   tests = 0, fails = 0;
  int   n_push = 0, n_strobe = 0;
  logic prev_dv = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] d, input logic [2:0] s, input logic e, input logic db);
    exp_t x;
    x.d = d; x.s = s; x.e = e; x.db = db;
    sb.push_back(x);
    n_push++;
  endtask

  // Encoder model: bit i of the result is codeword position i+1
  function automatic logic [7:0] enc(input logic [3:0] d);
    logic [7:0] w;
    w    = '0;
    w[2] = d[0]; w[4] = d[1]; w[5] = d[2]; w[6] = d[3];
    w[0] = d[0] ^ d[1] ^ d[3];
    w[1] = d[0] ^ d[2] ^ d[3];
    w[3] = d[1] ^ d[2] ^ d[3];
    w[7] = ^w[6:0];
    return w;
  endfunction

  task automatic drive(input logic v, input logic s, input logic b);
    sin_valid = v; sof = s; sin = b;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] fr, input int gap_at, input int gap_len);
    for (int i = 0; i < N; i++) begin
      if (i == gap_at) idle(gap_len);
      drive(1'b1, i == 0, fr[i]);
    end
  endtask

  // Scoreboard check on every strobe, sampled on the falling edge
  always @(negedge clk) begin
    if (data_valid) begin
      exp_t e;
      n_strobe++;
      chk("dv_one_cycle", 32'(prev_dv), 32'd0);
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL unexpected_strobe: got data_valid=1 expected no strobe");
      end else begin
        e = sb.pop_front();
        chk("data", 32'(data), 32'(e.d));
        chk("syndrome", 32'(syndrome), 32'(e.s));
        chk("err_corr", 32'(err_corr), 32'(e.e));
        chk("dbl_err", 32'(dbl_err), 32'(e.db));
      end
    end
    prev_dv = data_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] clean, fr, m;
    int p;
    logic [3:0] d;
    clean = enc(4'b1011);  // 1,0,1,0,1,0,1 (,0)

    // Reset state
    #12;
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_dv", 32'(data_valid), 32'd0);
    chk("rst_err", 32'(err_corr), 32'd0);
    chk("rst_syn", 32'(syndrome), 32'd0);
    chk("rst_dbl", 32'(dbl_err), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Clean frame
    push(4'b1011, 3'd0, 1'b0, 1'b0);
    send_frame(clean, -1, 0);
    idle(2);

    // Single errors: a data position (6) and a parity position (4)
    fr = clean; fr[5] = ~fr[5];
    push(4'b1011, 3'd6, 1'b1, 1'b0);
    send_frame(fr, -1, 0);
    fr = clean; fr[3] = ~fr[3];
    push(4'b1011, 3'd4, 1'b1, 1'b0);
    send_frame(fr, -1, 0);
    idle(2);

    // Reset mid-frame clears held outputs; the tail of that frame is ignored
    for (int i = 0; i < 4; i++) drive(1'b1, i == 0, clean[i]);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_data", 32'(data), 32'd0);
    chk("midrst_dv", 32'(data_valid), 32'd0);
    chk("midrst_err", 32'(err_corr), 32'd0);
    chk("midrst_syn", 32'(syndrome), 32'd0);
    chk("midrst_dbl", 32'(dbl_err), 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 4; i < N; i++) drive(1'b1, 1'b0, clean[i]);
    idle(3);

    // Gap of 3 cycles between bits 2 and 3, then an all-zero frame back to back
    push(4'b1011, 3'd0, 1'b0, 1'b0);
    push(4'b0000, 3'd0, 1'b0, 1'b0);
    send_frame(clean, 2, 3);
    send_frame(8'h00, -1, 0);
    idle(2);

    // Abort: 4 bits, then sof restarts with an all-zero frame
    push(4'b0000, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, i == 0, clean[i]);
    send_frame(8'h00, -1, 0);
    idle(2);

`ifdef HAMMING_SECDED_EN
    // Double error on pos1+pos2: flagged, uncorrected
    fr = clean; fr[0] = ~fr[0]; fr[1] = ~fr[1];
    push(4'b1011, 3'd3, 1'b0, 1'b1);
    send_frame(fr, -1, 0);
    // Error on the overall parity bit only
    fr = clean; fr[7] = ~fr[7];
    push(4'b1011, 3'd0, 1'b1, 1'b0);
    send_frame(fr, -1, 0);
    idle(2);
`endif

    // Random nibbles with no error or one error anywhere in the frame
    for (int k = 0; k < 12; k++) begin
      d = 4'($urandom_range(0, 15));
      p = $urandom_range(0, N);
      fr = enc(d);
      if (p != 0) begin
        m = 8'd1 << (p - 1);
        fr = fr ^ m;
      end
      push(d, (p <= 7) ? 3'(p) : 3'd0, p != 0, 1'b0);
      send_frame(fr, (k % 3 == 0) ? 4 : -1, k % 4);
    end

    // Drain the scoreboard with a bounded wait
    for (int c = 0; c < 20 && sb.size() != 0; c++) idle(1);
    idle(2);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("strobe_count", 32'(n_strobe), 32'(n_push));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
